// File: rtl/cpu_multicycle.sv
// cpu_multicycle: MIPS-I subset multi-cycle core over one shared req/ack memory port.
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int RF_DEPTH = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);
  localparam int RW = $clog2(RF_DEPTH);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_y, r_mdr, r_wdata;
  logic [31:0] r_rf [RF_DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic r_req, r_we, r_retire, r_halted, r_illegal;
  logic [5:0] w_op, w_fn;
  logic [RW-1:0] w_rs, w_rt, w_rd, w_dst;
  logic [31:0] w_imm, w_pc4, w_br, w_jt, w_alu, w_maddr, w_wb;
  logic w_rtype, w_legal;
  assign w_op = r_ir[31:26];
  assign w_fn = r_ir[5:0];
  assign w_rs = r_ir[21 +: RW];
  assign w_rt = r_ir[16 +: RW];
  assign w_rd = r_ir[11 +: RW];
  assign w_imm = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rtype = w_op == OP_R;
  assign w_legal = w_rtype ? (w_fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
                           : (w_op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});
  assign w_pc4 = r_pc + 32'd4;
  assign w_br = w_pc4 + {w_imm[29:0], 2'b00};
  assign w_jt = {w_pc4[31:28], r_ir[25:0], 2'b00};
  assign w_alu = !w_rtype ? r_a + w_imm :
                 w_fn == 6'h22 ? r_a - r_b :
                 w_fn == 6'h24 ? r_a & r_b :
                 w_fn == 6'h25 ? r_a | r_b :
                 w_fn == 6'h2A ? {31'd0, $signed(r_a) < $signed(r_b)} : r_a + r_b;
  assign w_maddr = {w_alu[31:2], 2'b00};
  assign w_dst = w_rtype ? w_rd : w_rt;
  assign w_wb = w_op == OP_LW ? r_mdr : r_y;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_a <= '0;
      r_b <= '0;
      r_y <= '0;
      r_mdr <= '0;
      r_wdata <= '0;
      r_addr <= '0;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        FETCH: begin
          // request goes out one cycle after entry so retire and the next fetch never overlap
          if (!r_req) begin
            r_req <= 1'b1;
            r_we <= 1'b0;
            r_addr <= r_pc[ADDR_W-1:0];
          end else if (mem_ack) begin
            r_req <= 1'b0;
            r_ir <= mem_rdata;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_a <= r_rf[w_rs];
          r_b <= r_rf[w_rt];
          if (!w_legal) begin
            r_state <= HALT;
            r_halted <= 1'b1;
            r_illegal <= 1'b1;
          end else if (w_op == OP_J) begin
            r_pc <= w_jt;
            r_retire <= 1'b1;
            r_state <= FETCH;
          end else r_state <= EXEC;
        end
        EXEC: begin
          r_y <= w_alu;
          if (w_op == OP_BEQ) begin
            r_pc <= r_a == r_b ? w_br : w_pc4;
            r_retire <= 1'b1;
            r_state <= FETCH;
          end else if (w_op == OP_LW || w_op == OP_SW) begin
            r_req <= 1'b1;
            r_we <= w_op == OP_SW;
            r_addr <= w_maddr[ADDR_W-1:0];
            r_wdata <= r_b;
            r_state <= MEM;
          end else r_state <= WB;
        end
        MEM: begin
          if (mem_ack) begin
            r_req <= 1'b0;
            r_we <= 1'b0;
            r_mdr <= mem_rdata;
            r_state <= r_we ? FETCH : WB;
            r_pc <= r_we ? w_pc4 : r_pc;
            r_retire <= r_we;
          end
        end
        WB: begin
          if (w_dst != '0) r_rf[w_dst] <= w_wb;
          r_pc <= w_pc4;
          r_retire <= 1'b1;
          r_state <= FETCH;
        end
        default: r_req <= 1'b0;
      endcase
    end
  end
  assign mem_req = r_req;
  assign mem_we = r_we;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign pc = r_pc;
  assign retire = r_retire;
  assign halted = r_halted;
  assign illegal = r_illegal;
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: scoreboard bench; stimulus queues expected transfers/retires, a monitor checks them.
module tb_cpu_multicycle;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_req, mem_we, mem_ack, retire, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  cpu_multicycle dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
    .retire(retire), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
  typedef struct { logic [31:0] pc; int lat; } ret_t;
  xfer_t tq[$];
  ret_t rq[$];
  logic [31:0] mem [logic [31:0]];
  int waits = 0, n_tests = 0, n_fail = 0, cyc = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction
  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rdst, logic [5:0] fn);
    return {6'h00, rs, rt, rdst, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction
  task automatic ins(logic [31:0] a, logic [31:0] w, logic [31:0] npc, int lat);
    mem[a] = w;
    tq.push_back('{1'b0, a, 32'd0});
    rq.push_back('{npc, lat});
  endtask
  task automatic fetch_only(logic [31:0] a, logic [31:0] w);
    mem[a] = w;
    tq.push_back('{1'b0, a, 32'd0});
  endtask
  task automatic xfer(logic we, logic [31:0] a, logic [31:0] d);
    tq.push_back('{we, a, d});
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tq.delete();
    rq.delete();
    mem.delete();
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic drain(string tag);
    for (int i = 0; i < 600 && (tq.size() + rq.size()) > 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    #2;
    chk({tag, "_drain"}, tq.size() + rq.size(), 0);
  endtask
  task automatic post(string tag, logic [31:0] hpc);
    chk({tag, "_halted"}, 32'(halted), 1);
    chk({tag, "_illegal"}, 32'(illegal), 1);
    chk({tag, "_req_idle"}, 32'(mem_req), 0);
    chk({tag, "_halt_pc"}, pc, hpc);
  endtask
  // memory responder: acks after `waits` wait states, stores on the ack cycle
  initial begin : resp
    int wc;
    wc = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        mem_ack = (wc == waits);
        mem_rdata = rd(mem_addr);
        wc = mem_ack ? 0 : wc + 1;
        if (mem_ack && mem_we) mem[mem_addr] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        wc = 0;
      end
    end
  end
  initial begin : mon
    xfer_t e;
    ret_t r;
    int run, start;
    logic need, stable;
    logic [64:0] snap;
    run = 0;
    start = 0;
    need = 1'b1;
    stable = 1'b1;
    snap = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        need = 1'b1;
        run = 0;
      end else begin
        if (mem_req) begin
          if (run == 0) begin
            snap = {mem_we, mem_addr, mem_wdata};
            stable = 1'b1;
          end else if (snap !== {mem_we, mem_addr, mem_wdata}) stable = 1'b0;
          run++;
          if (need) begin
            start = cyc;
            need = 1'b0;
          end
          if (mem_ack) begin
            if (tq.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL xfer: unexpected transfer addr %h we %b, none required", mem_addr, mem_we);
            end else begin
              e = tq.pop_front();
              chk("xfer_addr", mem_addr, e.addr);
              chk("xfer_we", 32'(mem_we), 32'(e.we));
              if (e.we) chk("xfer_wdata", mem_wdata, e.data);
              chk("req_cycles", run, waits + 1);
              chk("req_stable", 32'(stable), 1);
            end
            run = 0;
          end
        end
        if (retire) begin
          if (rq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL retire: unexpected retire with pc %h, none required", pc);
          end else begin
            r = rq.pop_front();
            chk("retire_pc", pc, r.pc);
            chk("retire_latency", cyc - start, r.lat);
          end
          need = 1'b1;
        end
      end
    end
  end
  initial begin : stim
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);
    // ALU ops, stores, misaligned lw, writes to $0, then halt on opcode 0x3F
    do_reset();
    waits = 0;
    ins(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5), 32'h04, 4);
    ins(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd7), 32'h08, 4);
    ins(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h0C, 4);
    ins(32'h0C, enc_i(6'h2B, 5'd0, 5'd3, 16'h0080), 32'h10, 4);
    xfer(1'b1, 32'h80, 32'd12);
    ins(32'h10, enc_r(5'd1, 5'd2, 5'd4, 6'h22), 32'h14, 4);
    ins(32'h14, enc_i(6'h2B, 5'd0, 5'd4, 16'h0084), 32'h18, 4);
    xfer(1'b1, 32'h84, 32'hFFFF_FFFE);
    ins(32'h18, enc_r(5'd4, 5'd1, 5'd5, 6'h2A), 32'h1C, 4);
    ins(32'h1C, enc_i(6'h2B, 5'd0, 5'd5, 16'h0088), 32'h20, 4);
    xfer(1'b1, 32'h88, 32'd1);
    ins(32'h20, enc_r(5'd1, 5'd2, 5'd6, 6'h24), 32'h24, 4);
    ins(32'h24, enc_r(5'd1, 5'd4, 5'd7, 6'h25), 32'h28, 4);
    ins(32'h28, enc_i(6'h2B, 5'd0, 5'd6, 16'h008C), 32'h2C, 4);
    xfer(1'b1, 32'h8C, 32'd5);
    ins(32'h2C, enc_i(6'h2B, 5'd0, 5'd7, 16'h0090), 32'h30, 4);
    xfer(1'b1, 32'h90, 32'hFFFF_FFFF);
    ins(32'h30, enc_i(6'h23, 5'd0, 5'd8, 16'h0083), 32'h34, 5);
    xfer(1'b0, 32'h80, 32'd0);
    ins(32'h34, enc_i(6'h2B, 5'd0, 5'd8, 16'h0094), 32'h38, 4);
    xfer(1'b1, 32'h94, 32'd12);
    ins(32'h38, enc_i(6'h08, 5'd0, 5'd0, 16'd9), 32'h3C, 4);
    ins(32'h3C, enc_r(5'd0, 5'd0, 5'd5, 6'h20), 32'h40, 4);
    ins(32'h40, enc_i(6'h2B, 5'd0, 5'd5, 16'h0098), 32'h44, 4);
    xfer(1'b1, 32'h98, 32'd0);
    fetch_only(32'h44, 32'hFC00_0000);
    mem[32'h48] = enc_i(6'h2B, 5'd0, 5'd1, 16'h009C);
    release_rst();
    drain("alu");
    post("alu", 32'h44);
    // three wait states on every phase
    do_reset();
    waits = 3;
    mem[32'h08] = 32'hDEAD_BEEF;
    ins(32'h00, enc_i(6'h23, 5'd0, 5'd4, 16'h0008), 32'h04, 11);
    xfer(1'b0, 32'h08, 32'd0);
    ins(32'h04, enc_i(6'h2B, 5'd0, 5'd4, 16'h0080), 32'h08, 10);
    xfer(1'b1, 32'h80, 32'hDEAD_BEEF);
    fetch_only(32'h08, 32'hDEAD_BEEF);
    release_rst();
    drain("wait");
    post("wait", 32'h08);
    // jumps across regions, beq taken backwards then not taken
    do_reset();
    waits = 0;
    ins(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd3), 32'h04, 4);
    ins(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd3), 32'h08, 4);
    ins(32'h08, enc_j(26'h010_0000), 32'h0040_0000, 2);
    ins(32'h0040_0000, enc_j(26'h000_0040), 32'h100, 2);
    ins(32'h100, enc_j(26'h000_0004), 32'h10, 2);
    ins(32'h10, enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'h0C, 3);
    ins(32'h0C, enc_i(6'h08, 5'd0, 5'd2, 16'd4), 32'h10, 4);
    ins(32'h10, enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'h14, 3);
    fetch_only(32'h14, 32'hFC00_0000);
    release_rst();
    drain("branch");
    post("branch", 32'h14);
    // async reset while a fetch is pending
    do_reset();
    waits = 5;
    ins(32'h00, enc_i(6'h08, 5'd0, 5'd7, 16'h0055), 32'h04, 9);
    release_rst();
    for (int i = 0; i < 100 && rq.size() > 0; i++) @(negedge clk);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(mem_req), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(mem_req), 0);
    chk("rst_async_pc", pc, 0);
    chk("rst_prior_done", tq.size() + rq.size(), 0);
    repeat (2) @(negedge clk);
    mem.delete();
    waits = 0;
    ins(32'h00, enc_i(6'h2B, 5'd0, 5'd7, 16'h0080), 32'h04, 4);
    xfer(1'b1, 32'h80, 32'd0);
    fetch_only(32'h04, 32'hFC00_0000);
    release_rst();
    drain("abort");
    post("abort", 32'h04);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle CPU top. It executes a MIPS-I integer subset through a FETCH/DECODE/EXEC/MEM/WB state machine over one shared instruction/data memory port with a req/ack handshake, so memory may insert wait states. It holds its own register file and ALU, and exposes retire and halt status for the bench and for a future debug block.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- RF_DEPTH, 32: number of registers, power of 2 in 2..32. The register index is the low log2(RF_DEPTH) bits of the 5-bit rs/rt/rd fields.
- ADDR_W, 32: memory address width, 2..32. mem_addr is the low ADDR_W bits of the byte address.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req=1.
- mem_addr  out  ADDR_W  byte address; word-aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled in the cycle where mem_req&mem_ack.
- mem_ack  in  1  transfer complete this cycle.
- pc  out  32  address of the instruction being executed.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sticky; core stopped.
- illegal  out  1  sticky; cause of halt was an unsupported opcode or funct.

## Operation
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Any other op/funct is illegal and moves the core to HALT.
- Arithmetic: add/sub/addi wrap modulo 2^32 with no overflow trap. slt is a signed compare and writes 0 or 1. Immediates are sign-extended to 32 bits.
- Register 0 always reads 0. Writes to it are discarded.
- lw/sw address = rs + sext(imm). Bits [1:0] are forced to 0.
- beq target = PC+4 + (sext(imm) << 2), with the shift applied before the add. Not taken: PC+4.
- j target = {PC+4[31:28], imm26, 2'b00}.
- State machine:
  - FETCH: req, we=0, addr=PC. On ack, latch IR and go to DECODE.
  - DECODE: read rs/rt into A/B. j: update PC, retire, go to FETCH. Illegal: go to HALT. Otherwise go to EXEC.
  - EXEC: ALU result into Y. beq: update PC, retire, go to FETCH. lw/sw: go to MEM. R-type/addi: go to WB.
  - MEM: req, addr=Y, we=1 for sw with wdata=B. On ack: sw updates PC, retires and goes to FETCH; lw latches the data and goes to WB.
  - WB: write rd (R-type) or rt (addi/lw). Update PC to PC+4, retire, go to FETCH.
  - HALT: terminal until rst. mem_req=0, halted=1.
- Reset values:
  - All registers are 0 and IR is 0.
  - Outputs: pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0, illegal=0.
  - State is FETCH. mem_req rises in the first cycle after rst deasserts.

## Timing
- mem_req, mem_we, mem_addr and mem_wdata are registered outputs, stable while a request is pending.
- A transfer completes in the cycle where req=1 and ack=1, including the very first cycle of the request (zero wait states).
- mem_req drops in the cycle after the ack. It is never asserted two cycles in a row for the same transfer once acked.
- ack while req=0 is ignored.
- Cycle counts with zero wait states, from the first FETCH cycle to the retire pulse inclusive:
  - j: 2
  - beq: 3
  - R-type/addi: 4
  - sw: 4
  - lw: 5
- Each wait state adds one cycle per memory phase.
- The next FETCH request is issued in the cycle after retire.
- pc changes in the same edge as the retire pulse.
- rst asserted mid-transfer (req pending or acked) clears mem_req immediately and asynchronously. The partial instruction has no architectural effect: no register write and no PC change.
- A register written in WB is visible to the DECODE of the next instruction. No forwarding is needed.

## Test plan
- Reset then ack tied to 1, with add $3,$1,$2 where $1=5 and $2=7: retire after 4 cycles, $3=12, pc=RESET_PC+4.
- Wait states: ack delayed 3 cycles on every request, lw $4,8($0) with mem[8]=0xDEADBEEF: mem_req held stable for 4 cycles per phase, $4=0xDEADBEEF, retire after 11 cycles.
- beq taken at PC=0x10 with imm=-2 and equal registers: next fetch address 0x0C. Not taken: next fetch address 0x14.
- j imm26=0x0000040 at PC=0x00400000: next fetch address 0x00000100. addi $0,$0,9 then add $5,$0,$0: $5=0.
- Illegal opcode 0x3F: halted=1 and illegal=1 after DECODE, no further mem_req; a sw placed after it is never issued.
- rst pulsed while a FETCH is pending: mem_req=0 in the same cycle; after release, fetch restarts at RESET_PC and registers read 0.
